inst_issuer: RTL
================

Name: inst_issuer

Overview:
- Initiator side of the Control instruction interface (`inst` / `inst_valid`).
- Buffers a program pushed by the host or testbench into an instruction FIFO. On `start`, issues the instructions one at a time to Control, pacing on Control's `ctrl_ready`.
- Stops at an END marker and pulses `done`. Sits between the host/test harness and the accelerator top level.

Parameters:
- INST_WIDTH, 27: instruction width. Must match Control.
- DEPTH, 16: FIFO entries. Power of two, at least 2.
- CNT_WIDTH, 5: width of `fifo_count`. Equals log2(DEPTH)+1.
- END_OPCODE, 5'h1F: value of inst[INST_WIDTH-1:INST_WIDTH-5] that marks end of program.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- host_inst  in  INST_WIDTH  instruction to push
- host_valid  in  1  push request
- host_ready  out  1  FIFO can accept a push
- start  in  1  single-cycle pulse: begin issuing
- abort  in  1  synchronous flush and return to IDLE
- ctrl_ready  in  1  Control can accept an instruction (high when not executing)
- inst  out  INST_WIDTH  instruction to Control
- inst_valid  out  1  single-cycle issue strobe
- busy  out  1  FSM not IDLE
- done  out  1  single-cycle pulse: program finished
- fifo_count  out  CNT_WIDTH  entries held
- issued_cnt  out  16  instructions issued since last start

Behaviour:
- Reset: every output is 0 except `host_ready`, which is 1. FIFO pointers and count are 0. FSM is IDLE.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo DEPTH.
  - A push happens when host_valid && host_ready.
  - host_ready = (count != DEPTH), computed from the registered count. When full, a pop in the same cycle does not enable a push.
  - Push and pop in the same cycle leave count unchanged.
  - Pushes are accepted in every FSM state.
- FSM states:
  - IDLE:
    - start=1 → RUN, with issued_cnt cleared to 0 in the same cycle.
    - start while busy is ignored.
  - RUN: issue condition = FIFO non-empty, ctrl_ready=1, and inst_valid=0 in the previous cycle.
    - This enforces at least one idle cycle between issues, so Control can deassert ready.
    - When the condition holds, pop the head entry.
    - If the head opcode == END_OPCODE: do not issue it (inst_valid stays 0) and go to DRAIN.
    - Otherwise register the head into `inst` and set inst_valid=1 for exactly one cycle; issued_cnt increments and saturates at 16'hFFFF.
    - Latency: start in cycle N gives the first inst_valid in cycle N+1 at the earliest (FIFO non-empty, ctrl_ready=1).
    - If the FIFO is empty, stall in RUN. This is an underrun: no timeout, and issuing resumes when the host pushes more instructions.
  - DRAIN: wait for ctrl_ready=1 (last instruction complete), then pulse done=1 for one cycle and go to IDLE.
- `inst` holds the last issued value between strobes. Only inst_valid qualifies it.
- `busy` is 1 in RUN and DRAIN.
- abort (any state):
  - Next cycle: FIFO flushed (count=0), FSM in IDLE, inst_valid=0, done not pulsed. issued_cnt keeps its value.
  - A host push in the abort cycle is discarded.
  - abort has priority over start.
- Asynchronous reset mid-operation clears all state immediately. FIFO contents are lost.
- Entries after END stay in the FIFO and are issued by the next start.

Test Plan:
- Basic program: push 3 instructions 27'h0000123, 27'h0000456, then END (27'h7C00000); hold ctrl_ready=1; pulse start → inst_valid strobes carry 123 then 456, spaced by one idle cycle; done pulses once after END; issued_cnt=2; fifo_count=0; busy falls with done.
- Ready pacing: same program; drop ctrl_ready for 10 cycles after each issue → the next issue waits until ctrl_ready returns high; no inst_valid while ctrl_ready=0; done waits for ctrl_ready in DRAIN.
- Full FIFO: push 17 instructions with host_valid held high → host_ready=0 after 16 accepted; fifo_count=16; the 17th is accepted only after the first pop; pointer wrap is verified by issuing 20 instructions plus END in total.
- Underrun: push 2 instructions without END and start → 2 issues, then busy stays 1 with no strobes; push END 50 cycles later → done pulses.
- Abort and start priority: abort while in RUN with 5 entries left → next cycle fifo_count=0, busy=0, no done; assert start and abort in the same cycle → remains IDLE.
- Reset mid-run: deassert rstn asynchronously between clock edges → all outputs are 0 and host_ready=1 immediately; no further inst_valid after release.

Source files
------------

// File: rtl/inst_issuer_if.sv
// -----------------------------------------------------------------------------
// inst_issuer_if
// Simple valid/ready instruction channel. Used twice by inst_issuer:
//   - host side : the host pushes program words into the issuer (issuer = slave)
//   - ctrl side : the issuer hands instructions to Control (issuer = master)
// Signals:
//   data  - instruction word, WIDTH bits
//   valid - driven by the master, qualifies data
//   ready - driven by the slave, it can take a word
// -----------------------------------------------------------------------------
interface inst_issuer_if #(
    parameter int WIDTH = 27
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/inst_issuer.sv
// -----------------------------------------------------------------------------
// inst_issuer
// Initiator side of the Control instruction interface. A program is pushed by
// the host into an instruction FIFO. A start pulse makes the issuer hand the
// buffered instructions to Control one at a time, paced by Control's ready.
// The issuer stops at an END marker (opcode == END_OPCODE), waits for Control
// to finish the last instruction and then pulses done.
//
// Ports:
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   host       - slave channel: host.data = host_inst, host.valid = host_valid,
//                host.ready = host_ready (FIFO not full)
//   ctrl       - master channel: ctrl.data = inst, ctrl.valid = inst_valid
//                (one-cycle strobe), ctrl.ready = ctrl_ready from Control
//   start      - one-cycle pulse, begin issuing (ignored while busy)
//   abort      - synchronous flush of the FIFO and return to IDLE
//   busy       - FSM is in RUN or DRAIN
//   done       - one-cycle pulse when the program has finished
//   fifo_count - number of entries held in the FIFO
//   issued_cnt - instructions issued since the last start (saturating)
// -----------------------------------------------------------------------------
module inst_issuer #(
    parameter int           INST_WIDTH = 27,
    parameter int           DEPTH      = 16,
    parameter int           CNT_WIDTH  = 5,
    parameter logic [4:0]   END_OPCODE = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rstn,
    inst_issuer_if.slave         host,
    inst_issuer_if.master        ctrl,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic [15:0]          issued_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [INST_WIDTH-1:0]  inst_q, inst_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   done_q, done_d;
    logic [15:0]            issued_cnt_q, issued_cnt_d;

    logic [INST_WIDTH-1:0]  mem_q [DEPTH];

    logic [INST_WIDTH-1:0]  head;
    logic                   head_is_end;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   issue_window;
    logic                   pop;
    logic [15:0]            cnt_base;

    assign head        = mem_q[rd_ptr_q];
    assign head_is_end = (head[INST_WIDTH-1 -: 5] == END_OPCODE);
    assign fifo_full   = (count_q == CNT_WIDTH'(DEPTH));
    assign fifo_empty  = (count_q == '0);

    // Full is judged on the registered count only, so a pop in the same cycle
    // never opens room for a push. A push during abort is dropped with the flush.
    assign push = host.valid && !fifo_full && !abort;

    // The start cycle itself is treated as a RUN cycle so that the first strobe
    // can appear in the cycle right after start.
    assign issue_window = (state_q == ST_RUN) || ((state_q == ST_IDLE) && start);

    // Requiring inst_valid low in the current cycle forces one idle cycle
    // between strobes, giving Control time to drop ready.
    assign pop = issue_window && !fifo_empty && ctrl.ready && !inst_valid_q && !abort;

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_WIDTH'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_WIDTH'(1);
            end
        end
    end

    // Storage array carries no reset; its contents are only meaningful
    // between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host.data;
        end
    end

    // Issue FSM: next state, issue strobe, done pulse and issue counter.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        done_d       = 1'b0;
        issued_cnt_d = issued_cnt_q;
        cnt_base     = issued_cnt_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (state_q == ST_IDLE && start) begin
                        state_d      = ST_RUN;
                        cnt_base     = '0;
                        issued_cnt_d = '0;
                    end
                    if (pop) begin
                        if (head_is_end) begin
                            state_d = ST_DRAIN;
                        end else begin
                            inst_d       = head;
                            inst_valid_d = 1'b1;
                            issued_cnt_d = (cnt_base == 16'hFFFF) ? cnt_base
                                                                  : cnt_base + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Control raises ready once the last instruction completes.
                    if (ctrl.ready) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign host.ready = !fifo_full;
    assign ctrl.data  = inst_q;
    assign ctrl.valid = inst_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign fifo_count = count_q;
    assign issued_cnt = issued_cnt_q;

endmodule
